// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Reports the data word with a parity check, or a framing error when the stop bit is low.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | line idle, waiting for a start bit (rx=0 on a strobe)
// S_DATA      | shifting in DATA_W data bits, LSB first
// S_PARITY    | capturing the parity bit
// S_STOP      | sampling the stop bit, publishing the word or a framing error
// S_WAIT_IDLE | after a framing error, waiting for the line to return high
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            case (state_q)
                S_IDLE:      if (!rx) state_d = S_DATA;
                S_DATA:      if (cnt_q == LAST_BIT) state_d = S_PARITY;
                S_PARITY:    state_d = S_STOP;
                S_STOP:      state_d = rx ? S_IDLE : S_WAIT_IDLE;
                S_WAIT_IDLE: if (rx) state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx) cnt_d = '0;
                end
                S_DATA: begin
                    // shift form works for DATA_W=1 where a [DATA_W-1:1] slice would not
                    shreg_d = (shreg_q >> 1) | (DATA_W'(rx) << (DATA_W - 1));
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                S_PARITY: begin
                    par_d = rx;
                end
                S_STOP: begin
                    if (rx) begin
                        dout_d  = shreg_q;
                        valid_d = 1'b1;
                        perr_d  = (((^shreg_q) ^ par_q) != ODD_PARITY);
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: an odd-parity and an even-parity instance
// share the same serial line; frames come from a vector table plus hand-written sequences.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_en;
    logic       rx;
    logic [7:0] dout_o, dout_e;
    logic       valid_o, perr_o, ferr_o, busy_o;
    logic       valid_e, perr_e, ferr_e, busy_e;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
        .data_out(dout_o), .data_valid(valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
        .data_out(dout_e), .data_valid(valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    typedef struct {
        logic [7:0] data;
        logic       p;
        logic       stop;
        int         gap;
        bit         noise;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr_o;
        logic       exp_perr_e;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one strobe; gap-1 idle clocks precede it, optionally with rx noise
    task automatic strobe(input logic b, input int gap, input bit noise);
        for (int k = 1; k < gap; k++) begin
            @(negedge clk);
            bit_en = 1'b0;
            if (noise) rx = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rx     = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int gap, input bit noise);
        strobe(1'b0, gap, noise);
        for (int i = 0; i < 8; i++) strobe(d[i], gap, noise);
        strobe(p, gap, noise);
        strobe(stop, gap, noise);
    endtask

    task automatic quiet_cycle();
        @(negedge clk);
        bit_en = 1'b0;
        rx     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[1] = '{8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};

        rst_n  = 1'b0;
        bit_en = 1'b0;
        rx     = 1'b1;
        #1;
        chk("reset data_out", 32'(dout_o), 32'h0);
        chk("reset data_valid", 32'(valid_o), 32'h0);
        chk("reset busy", 32'(busy_o), 32'h0);
        chk("reset frame_err", 32'(ferr_o), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].p, vecs[v].stop, vecs[v].gap, vecs[v].noise);
            chk($sformatf("v%0d data_valid", v), 32'(valid_o), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d frame_err", v), 32'(ferr_o), 32'(vecs[v].exp_ferr));
            chk($sformatf("v%0d parity_err odd", v), 32'(perr_o), 32'(vecs[v].exp_perr_o));
            chk($sformatf("v%0d parity_err even", v), 32'(perr_e), 32'(vecs[v].exp_perr_e));
            chk($sformatf("v%0d data_out odd", v), 32'(dout_o), 32'(vecs[v].exp_dout));
            chk($sformatf("v%0d data_out even", v), 32'(dout_e), 32'(vecs[v].exp_dout));
            chk($sformatf("v%0d busy", v), 32'(busy_o), 32'(vecs[v].exp_ferr));

            quiet_cycle();
            chk($sformatf("v%0d pulses cleared", v),
                32'({valid_o, perr_o, ferr_o, valid_e, perr_e, ferr_e}), 32'h0);
            chk($sformatf("v%0d data_out held", v), 32'(dout_o), 32'(vecs[v].exp_dout));

            if (vecs[v].stop == 1'b0) begin
                for (int k = 0; k < 5; k++) begin
                    strobe(1'b0, 1, 1'b0);
                    chk($sformatf("v%0d wait_idle busy k%0d", v, k), 32'(busy_o), 32'h1);
                end
                strobe(1'b1, 1, 1'b0);
                chk($sformatf("v%0d back to idle", v), 32'({busy_o, busy_e}), 32'h0);
                quiet_cycle();
            end
        end

        // reset in the middle of a frame
        strobe(1'b0, 1, 1'b0);
        strobe(1'b1, 1, 1'b0);
        strobe(1'b0, 1, 1'b0);
        strobe(1'b1, 1, 1'b0);
        chk("midframe busy", 32'(busy_o), 32'h1);
        bit_en = 1'b0;
        rx     = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("midframe reset data_out", 32'(dout_o), 32'h0);
        chk("midframe reset busy", 32'({busy_o, busy_e}), 32'h0);
        chk("midframe reset pulses", 32'({valid_o, perr_o, ferr_o}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_cycle();

        // two frames back to back: start bit on the strobe right after stop
        send_frame(8'h5A, 1'b1, 1'b1, 1, 1'b0);
        chk("b2b1 data_valid", 32'(valid_o), 32'h1);
        chk("b2b1 data_out", 32'(dout_o), 32'h5A);
        chk("b2b1 parity_err", 32'(perr_o), 32'h0);
        chk("b2b1 busy", 32'(busy_o), 32'h0);
        send_frame(8'hC3, 1'b1, 1'b1, 1, 1'b0);
        chk("b2b2 data_valid", 32'(valid_o), 32'h1);
        chk("b2b2 data_out", 32'(dout_o), 32'hC3);
        chk("b2b2 parity_err", 32'(perr_o), 32'h0);
        chk("b2b2 even parity_err", 32'(perr_e), 32'h1);
        quiet_cycle();
        chk("b2b2 pulse cleared", 32'(valid_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
